// File: rtl/mem_cache_pkg.sv
// Shared geometry defaults and FSM state encoding for the direct-mapped data cache.
package mem_cache_pkg;

  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_LINES      = 64;

  typedef enum logic [1:0] {
    CACHE_IDLE  = 2'd0,
    CACHE_WBACK = 2'd1,
    CACHE_FILL  = 2'd2
  } cache_state_e;

endpackage

// File: rtl/mem_cache_store.sv
// Tag/data/valid/dirty arrays: asynchronous read of one line, synchronous CPU-word and fill-word writes.
module cache_store #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64,
  parameter int WW         = 2,
  parameter int IW         = 6,
  parameter int TW         = 22
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [IW-1:0] i_idx,
  input  logic [WW-1:0] i_rd_word,
  input  logic [WW-1:0] i_vic_word,
  output logic          o_valid,
  output logic          o_dirty,
  output logic [TW-1:0] o_tag,
  output logic [31:0]   o_rd_dat,
  output logic [31:0]   o_vic_dat,
  input  logic          i_cpu_we,
  input  logic [31:0]   i_cpu_dat,
  input  logic          i_fill_we,
  input  logic [WW-1:0] i_fill_word,
  input  logic [31:0]   i_fill_dat,
  input  logic          i_fill_done,
  input  logic [TW-1:0] i_fill_tag
);

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES][LINE_WORDS];

  assign o_valid   = r_valid[i_idx];
  assign o_dirty   = r_dirty[i_idx];
  assign o_tag     = r_tag[i_idx];
  assign o_rd_dat  = r_data[i_idx][i_rd_word];
  assign o_vic_dat = r_data[i_idx][i_vic_word];

  // Only the status bits are reset; tag and data contents are don't-care until a line is valid.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_done) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_cpu_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_cpu_we)
      r_data[i_idx][i_rd_word] <= i_cpu_dat;
    if (i_fill_we)
      r_data[i_idx][i_fill_word] <= i_fill_dat;
    if (i_fill_done)
      r_tag[i_idx] <= i_fill_tag;
  end

endmodule

// File: rtl/mem_cache.sv
// Direct-mapped write-back/write-allocate cache: hits in zero cycles, misses stall while the
// victim line is written back and the new line is filled word by word over a req/ack port.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int LINES      = DEF_LINES
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_ren,
  input  logic        i_cpu_wen,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_dout,
  output logic [31:0] o_cpu_din,
  output logic        o_cpu_stall,
  output logic        o_ram_req,
  output logic        o_ram_we,
  output logic [31:0] o_ram_addr,
  output logic [31:0] o_ram_dout,
  input  logic [31:0] i_ram_din,
  input  logic        i_ram_ack
);

  localparam int WW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - IW - WW - 2;

  cache_state_e r_state, w_state_nxt;
  logic [WW-1:0] r_cnt, w_cnt_nxt;
  logic          r_ram_req, r_ram_we;
  logic [31:0]   r_ram_addr, r_ram_dout;

  logic [WW-1:0] w_word;
  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag, w_tag_rd;
  logic          w_valid, w_dirty, w_hit, w_access, w_ack, w_last;
  logic [31:0]   w_rd_dat, w_vic_dat;
  logic          w_cpu_we, w_fill_we, w_fill_done, w_stall;
  logic          w_unused;

  assign w_word   = i_cpu_addr[WW+1:2];
  assign w_idx    = i_cpu_addr[IW+WW+1:WW+2];
  assign w_tag    = i_cpu_addr[31:IW+WW+2];
  assign w_unused = ^i_cpu_addr[1:0];

  assign w_access = i_cpu_ren | i_cpu_wen;
  assign w_hit    = w_valid & (w_tag_rd == w_tag);
  assign w_ack    = i_ram_ack & r_ram_req;
  assign w_last   = (r_cnt == WW'(LINE_WORDS - 1));

  cache_store #(
    .LINE_WORDS(LINE_WORDS), .LINES(LINES), .WW(WW), .IW(IW), .TW(TW)
  ) u_store (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_idx       (w_idx),
    .i_rd_word   (w_word),
    .i_vic_word  (w_cnt_nxt),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag_rd),
    .o_rd_dat    (w_rd_dat),
    .o_vic_dat   (w_vic_dat),
    .i_cpu_we    (w_cpu_we),
    .i_cpu_dat   (i_cpu_dout),
    .i_fill_we   (w_fill_we),
    .i_fill_word (r_cnt),
    .i_fill_dat  (i_ram_din),
    .i_fill_done (w_fill_done),
    .i_fill_tag  (w_tag)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cpu_we    = 1'b0;
    w_fill_we   = 1'b0;
    w_fill_done = 1'b0;
    w_stall     = 1'b0;
    o_cpu_din   = '0;
    case (r_state)
      CACHE_IDLE: begin
        if (w_access) begin
          if (w_hit) begin
            if (i_cpu_wen) w_cpu_we  = 1'b1;
            else           o_cpu_din = w_rd_dat;
          end else begin
            w_stall     = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (w_valid & w_dirty) ? CACHE_WBACK : CACHE_FILL;
          end
        end
      end
      CACHE_WBACK: begin
        w_stall = 1'b1;
        if (w_ack) begin
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) w_state_nxt = CACHE_FILL;
        end
      end
      CACHE_FILL: begin
        w_stall = 1'b1;
        if (w_ack) begin
          w_fill_we = 1'b1;
          w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            w_fill_done = 1'b1;
            w_state_nxt = CACHE_IDLE;
          end
        end
      end
      default: w_state_nxt = CACHE_IDLE;
    endcase
  end

  assign o_cpu_stall = w_stall & ~i_rst;

  // Memory outputs are registered from the next state, so they already carry the new word's
  // address in the cycle after an ack and hold steady while the memory keeps us waiting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= CACHE_IDLE;
      r_cnt      <= '0;
      r_ram_req  <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_dout <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ram_req  <= (w_state_nxt != CACHE_IDLE);
      r_ram_we   <= (w_state_nxt == CACHE_WBACK);
      r_ram_addr <= (w_state_nxt == CACHE_WBACK) ? {w_tag_rd, w_idx, w_cnt_nxt, 2'b00}
                                                 : {w_tag, w_idx, w_cnt_nxt, 2'b00};
      r_ram_dout <= (w_state_nxt == CACHE_WBACK) ? w_vic_dat : '0;
    end
  end

  assign o_ram_req  = r_ram_req;
  assign o_ram_we   = r_ram_we;
  assign o_ram_addr = r_ram_addr;
  assign o_ram_dout = r_ram_dout;

endmodule

// File: tb/tb_mem_cache.sv
// Randomized scoreboard bench for mem_cache: a line-level cache/memory model predicts load data,
// stall lengths and the exact memory transaction sequence; monitors compare as outputs appear.
module tb_mem_cache;

  localparam int LW = 4;
  localparam int NL = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_dout, cpu_din;
  logic        cpu_stall;
  logic        ram_req, ram_we, ram_ack;
  logic [31:0] ram_addr, ram_dout, ram_din;

  mem_cache #(.LINE_WORDS(LW), .LINES(NL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_ren(cpu_ren), .i_cpu_wen(cpu_wen), .i_cpu_addr(cpu_addr), .i_cpu_dout(cpu_dout),
    .o_cpu_din(cpu_din), .o_cpu_stall(cpu_stall),
    .o_ram_req(ram_req), .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_dout(ram_dout),
    .i_ram_din(ram_din), .i_ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Main memory contents and the value the CPU should observe at each word address.
  logic [31:0] ram   [int unsigned];
  logic [31:0] cview [int unsigned];

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ram.exists(w) ? ram[w] : ((w * 32'h9E37_79B1) ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] cpu_rd(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return cview.exists(w) ? cview[w] : ram_rd(w);
  endfunction

  // Line-level model of cache residency.
  logic        m_valid [NL];
  logic        m_dirty [NL];
  logic [21:0] m_tag   [NL];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } txn_t;

  txn_t        exp_ram[$];
  logic [31:0] exp_load[$];

  int mem_delay = 0;
  int wait_cnt  = 0;
  logic        prev_req = 1'b0, prev_we = 1'b0, prev_acked = 1'b0;
  logic [31:0] prev_addr = '0, prev_dout = '0;

  // Memory model plus memory-side monitor.
  always @(negedge clk) begin
    txn_t t;
    if (!rst && ram_req && prev_req && !prev_acked) begin
      chk("ram_addr_stable", ram_addr, prev_addr);
      chk("ram_we_dout_stable", {31'd0, ram_we} ^ ram_dout, {31'd0, prev_we} ^ prev_dout);
    end
    prev_req  = ram_req && !rst;
    prev_we   = ram_we;
    prev_addr = ram_addr;
    prev_dout = ram_dout;
    ram_ack   = 1'b0;
    prev_acked = 1'b0;
    if (!rst && ram_req) begin
      if (wait_cnt >= mem_delay) begin
        ram_ack    = 1'b1;
        prev_acked = 1'b1;
        wait_cnt   = 0;
        if (ram_we) ram[ram_addr] = ram_dout;
        else        ram_din = ram_rd(ram_addr);
        if (exp_ram.size() == 0) begin
          chk("ram_unexpected_req", ram_addr, 32'hFFFF_FFFF);
        end else begin
          t = exp_ram.pop_front();
          chk("ram_we", {31'd0, ram_we}, {31'd0, t.we});
          chk("ram_addr", ram_addr, t.addr);
          if (t.we) chk("ram_dout", ram_dout, t.dat);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Load-data monitor.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst && cpu_ren && !cpu_wen && !cpu_stall) begin
      if (exp_load.size() == 0) begin
        chk("load_unexpected", cpu_din, 32'hFFFF_FFFF);
      end else begin
        e = exp_load.pop_front();
        chk("load_data", cpu_din, e);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    cview.delete();
    exp_ram.delete();
  endtask

  task automatic access(input logic ren, input logic wen, input logic [31:0] addr,
                        input logic [31:0] dat, output int stalls);
    logic [5:0]  idx;
    logic [21:0] tag;
    logic [31:0] a;
    logic [1:0]  w2;
    int          nw;
    int          exp_stall;
    logic        hit;
    idx = addr[9:4];
    tag = addr[31:10];
    hit = m_valid[idx] && (m_tag[idx] == tag);
    nw  = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        for (int w = 0; w < LW; w++) begin
          w2 = 2'(w);
          a  = {m_tag[idx], idx, w2, 2'b00};
          exp_ram.push_back('{we: 1'b1, addr: a, dat: cpu_rd(a)});
          nw++;
        end
      end
      for (int w = 0; w < LW; w++) begin
        w2 = 2'(w);
        exp_ram.push_back('{we: 1'b0, addr: {tag, idx, w2, 2'b00}, dat: 32'd0});
        nw++;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    exp_stall = hit ? 0 : 1 + nw * (mem_delay + 1);
    if (wen) begin
      cview[{addr[31:2], 2'b00}] = dat;
      m_dirty[idx] = 1'b1;
    end else begin
      exp_load.push_back(cpu_rd(addr));
    end

    @(posedge clk);
    #1;
    cpu_ren  = ren;
    cpu_wen  = wen;
    cpu_addr = addr;
    cpu_dout = dat;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 500) begin
        chk("stall_timeout", 32'(stalls), 32'(exp_stall));
        break;
      end
    end
    if (exp_stall == 0) chk("hit_no_ram_req", {31'd0, ram_req}, 32'd0);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    @(posedge clk);
    #1;
    cpu_ren = 1'b0;
    cpu_wen = 1'b0;
  endtask

  initial begin
    int st;
    logic [31:0] a;
    rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_dout = '0;
    ram_ack = 1'b0; ram_din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cpu_ren  = 1'b1;
    cpu_addr = 32'h0000_0100;
    #2;
    chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
    chk("rst_din", cpu_din, 32'd0);
    chk("rst_ram_req", {31'd0, ram_req}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_dout", ram_dout, 32'd0);
    @(posedge clk);
    #1;
    cpu_ren = 1'b0;
    rst = 1'b0;

    // Directed scenarios
    access(1'b1, 1'b0, 32'h0000_0100, 32'd0, st);
    chk("cold_miss_stall", 32'(st), 32'd5);
    access(1'b1, 1'b0, 32'h0000_0108, 32'd0, st);
    chk("hit_0x108_stall", 32'(st), 32'd0);
    access(1'b0, 1'b1, 32'h0000_0104, 32'hDEAD_BEEF, st);
    chk("store_hit_stall", 32'(st), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0104, 32'd0, st);
    chk("load_after_store_stall", 32'(st), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0500, 32'd0, st);
    chk("dirty_miss_stall", 32'(st), 32'd9);
    chk("wback_deadbeef", ram_rd(32'h0000_0104), 32'hDEAD_BEEF);
    mem_delay = 3;
    access(1'b1, 1'b0, 32'h0000_0200, 32'd0, st);
    chk("slow_clean_miss_stall", 32'(st), 32'd17);
    mem_delay = 0;
    access(1'b1, 1'b1, 32'h0000_0208, 32'h1234_5678, st);
    chk("ren_wen_hit_stall", 32'(st), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0208, 32'd0, st);

    // Reset pulsed during the fill of the second word
    mem_delay = 1;
    for (int w = 0; w < LW; w++)
      exp_ram.push_back('{we: 1'b0, addr: 32'h0000_3040 + 32'(4 * w), dat: 32'd0});
    @(posedge clk);
    #1;
    cpu_ren  = 1'b1;
    cpu_addr = 32'h0000_3040;
    st = 0;
    forever begin
      @(negedge clk);
      if (ram_ack) break;
      st++;
      if (st > 50) begin
        chk("rst_test_ack_timeout", 32'(st), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_ram_req", {31'd0, ram_req}, 32'd0);
    chk("abort_stall", {31'd0, cpu_stall}, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_ren = 1'b0;
    access(1'b1, 1'b0, 32'h0000_3044, 32'd0, st);
    chk("refill_after_abort_stall", 32'(st), 32'd9);

    // Randomized traffic over a few conflicting tags and indices
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [21:0] tg;
      logic [5:0]  ix;
      logic [1:0]  wd;
      tg = 22'($urandom_range(0, 3) + 8);
      ix = 6'($urandom_range(0, 3));
      wd = 2'($urandom_range(0, 3));
      a  = {tg, ix, wd, 2'b00};
      mem_delay = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      if (kind < 2)       access(1'b1, 1'b0, a, 32'd0, st);
      else if (kind == 2) access(1'b0, 1'b1, a, $urandom, st);
      else                access(1'b1, 1'b1, a, $urandom, st);
    end

    repeat (3) @(posedge clk);
    chk("ram_queue_drained", 32'(exp_ram.size()), 32'd0);
    chk("load_queue_drained", 32'(exp_load.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
